pattern_match_ctrl: RTL and testbench
=====================================

// Module: pattern_match_ctrl
// PURPOSE
//   Programmable controller and scheduler for the serial sequence-detect datapath.
//   - Loads a pattern and its length through a valid/ready config port.
//   - Arms and disarms detection on a 1-bit serial input, with overlapping matches.
//   - Counts matches and stops in DONE when a programmed match target is reached.
//   - Sits between the config/CPU side and the serial bit stream it monitors.
// PARAMETERS
//   PAT_W  8  maximum pattern length in bits (>=2)
//   CNT_W  8  match counter / target width
//   LEN_W  $clog2(PAT_W)+1  width of cfg_len (derived)
// PORTS
//   clk          in   1      rising-edge clock, single clock domain
//   reset        in   1      synchronous, active-high reset
//   in           in   1      serial data bit, sampled every clk while ARMED
//   cfg_valid    in   1      config request
//   cfg_ready    out  1      combinational; 1 only in IDLE
//   cfg_pattern  in   PAT_W  pattern; bit [cfg_len-1] is the oldest/first bit
//   cfg_len      in   LEN_W  pattern length, legal 1..PAT_W
//   cfg_target   in   CNT_W  matches before DONE; 0 = run until stop
//   start        in   1      arm request (1-cycle pulse)
//   stop         in   1      abort request (1-cycle pulse)
//   out          out  1      registered; 1-cycle pulse per match
//   match_cnt    out  CNT_W  registered match count, saturating
//   busy         out  1      1 in ARMED
//   done         out  1      1 in DONE
//   cfg_err      out  1      registered 1-cycle pulse on an illegal cfg_len
// BEHAVIOUR
//   - Reset: state=IDLE. out, match_cnt, busy, done, cfg_err all 0.
//     cfg_loaded=0. Pattern, length, target, shift reg and fill count cleared.
//   - States and transitions:
//     IDLE
//       - cfg_valid&&cfg_ready with legal len: latch pattern/len/target, set cfg_loaded.
//       - Illegal len (0 or >PAT_W): cfg_err=1 next cycle; config and cfg_loaded unchanged.
//       - start && cfg_loaded && !cfg_valid -> ARMED. Clears match_cnt, shift reg, fill.
//       - start without cfg_loaded: ignored, stays IDLE.
//     ARMED
//       - Each cycle: sh <= {sh[PAT_W-2:0],in}; fill <= min(fill+1,PAT_W).
//       - Match when (fill+1)>=len and {sh,in}[len-1:0]==pattern[len-1:0].
//       - Matches overlap (1,0,1,0,1 with pattern 101 gives 2 matches).
//     DONE
//       - in ignored; out=0; match_cnt held.
//       - start -> ARMED with the same re-arm clearing as from IDLE.
//   - Match in cycle k (bit sampled at edge k):
//     - out=1 during cycle k+1 only.
//     - match_cnt increments in cycle k+1, saturating at 2^CNT_W-1 (no wrap).
//     - If target!=0 and the new count==target: state=DONE in cycle k+1.
//       busy=0 and done=1 the same cycle.
//   - Priority each cycle: reset > stop > start > cfg.
//     - stop in any state -> IDLE next cycle. A match on the stop cycle is discarded
//       (out stays 0, count unchanged). Config and cfg_loaded are retained.
//     - start in ARMED is ignored.
//     - cfg_valid and start together in IDLE: cfg accepted, start ignored.
//   - Reset mid-operation returns everything to the reset state; a new config is required.
//   - Latencies: start->busy 1 cycle; last pattern bit->out 1 cycle; stop->IDLE 1 cycle.
// TESTING
//   1. Overlap: cfg 101, len=3, target=0; start; in=1,0,1,0,1
//      -> out pulses the cycle after the 3rd and 5th bits; match_cnt=2; busy stays 1.
//   2. Target: cfg 11, len=2, target=2; in=1,1,1,1
//      -> out after bits 2 and 3; done=1 and busy=0 from the cycle after bit 3;
//      bit 4 ignored; match_cnt=2.
//   3. Bad config: cfg_len=0 -> cfg_err pulses 1 cycle, cfg_loaded stays 0;
//      start -> busy stays 0.
//   4. Abort: stop asserted on the cycle a 101 match completes
//      -> out=0, match_cnt unchanged, IDLE next cycle, cfg_ready=1.
//   5. Reset mid-run: ARMED after the 1,0 prefix of 101; reset
//      -> all outputs 0; start ignored until reconfigured.
//      Reconfigure and start; in=1 alone gives no match (fill cleared).
//   6. Saturation: CNT_W=2, pattern 1, len=1, target=0; 5 ones
//      -> 5 out pulses; match_cnt=3 and held.

Source files
------------

// File: rtl/pattern_match_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pattern_match_ctrl_if : valid/ready configuration port of pattern_match_ctrl |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface pattern_match_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_target;

  modport master (
    output cfg_valid,
    output cfg_pattern,
    output cfg_len,
    output cfg_target,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_pattern,
    input  cfg_len,
    input  cfg_target,
    output cfg_ready
  );
endinterface
`default_nettype wire

// File: rtl/pattern_match_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pattern_match_ctrl : programmable serial pattern detector with match count |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module pattern_match_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  pattern_match_ctrl_if.slave  cfg,
  input  logic                 in,
  input  logic                 start,
  input  logic                 stop,
  output logic                 out,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);
  localparam int               LEN_W   = $clog2(PAT_W) + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             loaded_q, loaded_d;
  logic [PAT_W-2:0] sh_q, sh_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [PAT_W-1:0] window;
  logic [LEN_W:0]   fill_inc;
  logic             bits_eq;
  logic             match;
  logic             len_ok;
  logic             arm;

  // The newest bit sits at window[0]; the shift register only needs PAT_W-1 history bits.
  assign window   = {sh_q, in};
  assign fill_inc = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};

  always_comb begin
    bits_eq = 1'b1;
    for (int i = 0; i < PAT_W; i++) begin
      if ((i < int'(len_q)) && (window[i] != pat_q[i])) begin
        bits_eq = 1'b0;
      end
    end
  end

  assign match  = (state_q == ST_ARMED) && (fill_inc >= {1'b0, len_q}) && bits_eq;
  assign len_ok = (cfg.cfg_len != '0) && (cfg.cfg_len <= MAX_LEN);
  assign arm    = start && ((state_q == ST_DONE) ||
                            ((state_q == ST_IDLE) && loaded_q && !cfg.cfg_valid));

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    tgt_d    = tgt_q;
    loaded_d = loaded_q;
    sh_d     = sh_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    out_d    = 1'b0;
    err_d    = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      state_d = ST_ARMED;
      cnt_d   = '0;
      sh_d    = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg.cfg_valid) begin
            if (len_ok) begin
              pat_d    = cfg.cfg_pattern;
              len_d    = cfg.cfg_len;
              tgt_d    = cfg.cfg_target;
              loaded_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_ARMED: begin
          sh_d   = window[PAT_W-2:0];
          fill_d = (fill_q == MAX_LEN) ? fill_q : fill_inc[LEN_W-1:0];
          if (match) begin
            out_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if ((tgt_q != '0) && (cnt_d == tgt_q)) begin
              state_d = ST_DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      tgt_q    <= '0;
      loaded_q <= 1'b0;
      sh_q     <= '0;
      fill_q   <= '0;
      out_q    <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      tgt_q    <= tgt_d;
      loaded_q <= loaded_d;
      sh_q     <= sh_d;
      fill_q   <= fill_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign out           = out_q;
  assign match_cnt     = cnt_q;
  assign busy          = (state_q == ST_ARMED);
  assign done          = (state_q == ST_DONE);
  assign cfg_err       = err_q;
  assign cfg.cfg_ready = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pattern_match_ctrl.sv
`default_nettype none
// Bench for pattern_match_ctrl: directed vector table, corner sequences,
// a CNT_W=2 instance for saturation, and random traffic against a history-based model.
module tb_pattern_match_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       din, start, stop;
  logic       dout, busy, done, cfg_err;
  logic [7:0] match_cnt;

  logic       s_in, s_start, s_stop;
  logic       s_out, s_busy, s_done, s_err;
  logic [1:0] s_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pattern_match_ctrl_if #(.PAT_W(8), .CNT_W(8)) cif ();
  pattern_match_ctrl_if #(.PAT_W(8), .CNT_W(2)) sif ();

  pattern_match_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cfg(cif.slave), .in(din), .start(start), .stop(stop),
    .out(dout), .match_cnt(match_cnt), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  pattern_match_ctrl #(.PAT_W(8), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .cfg(sif.slave), .in(s_in), .start(s_start), .stop(s_stop),
    .out(s_out), .match_cnt(s_cnt), .busy(s_busy), .done(s_done), .cfg_err(s_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rst, cv, pat, len, tgt, st, sp, b;
    int e_out, e_cnt, e_busy, e_done, e_err, e_rdy;
  } vec_t;

  vec_t vt[$];

  task automatic add(input int rst, cv, pat, len, tgt, st, sp, b,
                     input int eo, ec, eb, ed, ee, er);
    vec_t v;
    v.rst = rst; v.cv = cv; v.pat = pat; v.len = len; v.tgt = tgt;
    v.st = st; v.sp = sp; v.b = b;
    v.e_out = eo; v.e_cnt = ec; v.e_busy = eb; v.e_done = ed; v.e_err = ee; v.e_rdy = er;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic set_in(input int r, cv, p, l, t, st, sp, b);
    reset           = 1'(r);
    cif.cfg_valid   = 1'(cv);
    cif.cfg_pattern = 8'(p);
    cif.cfg_len     = 4'(l);
    cif.cfg_target  = 8'(t);
    start           = 1'(st);
    stop            = 1'(sp);
    din             = 1'(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: remembers the bits seen since arming and compares the tail
  // against the pattern read oldest-bit-first.
  int m_mode;   // 0 idle, 1 armed, 2 done
  int m_out, m_err, m_loaded, m_pat, m_len, m_tgt, m_cnt;
  bit hist[$];

  function automatic bit tail_match();
    int n;
    n = hist.size();
    if (n < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++) begin
      if (hist[n - m_len + j] != 1'((m_pat >> (m_len - 1 - j)) & 1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input int r, cv, p, l, t, st, sp, b);
    m_out = 0;
    m_err = 0;
    if (r != 0) begin
      m_mode = 0; m_cnt = 0; m_loaded = 0; m_pat = 0; m_len = 0; m_tgt = 0;
      hist.delete();
    end else if (sp != 0) begin
      m_mode = 0;
    end else if (st != 0 && (m_mode == 2 || (m_mode == 0 && m_loaded != 0 && cv == 0))) begin
      m_mode = 1;
      m_cnt  = 0;
      hist.delete();
    end else if (m_mode == 0) begin
      if (cv != 0) begin
        if (l >= 1 && l <= 8) begin
          m_pat = p; m_len = l; m_tgt = t; m_loaded = 1;
        end else begin
          m_err = 1;
        end
      end
    end else if (m_mode == 1) begin
      hist.push_back(1'(b));
      if (hist.size() > 8) void'(hist.pop_front());
      if (tail_match()) begin
        m_out = 1;
        if (m_cnt < 255) m_cnt++;
        if (m_tgt != 0 && m_cnt == m_tgt) m_mode = 2;
      end
    end
  endtask

  initial begin
    s_in = 1'b0; s_start = 1'b0; s_stop = 1'b0;
    sif.cfg_valid = 1'b0; sif.cfg_pattern = 8'd0; sif.cfg_len = 4'd0; sif.cfg_target = 2'd0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);

    //    rst cv pat  len tgt st sp b   out cnt busy done err rdy
    add(1, 1, 5, 3, 0, 1, 0, 1,      0, 0, 0, 0, 0, 1);
    add(0, 1, 5, 3, 0, 0, 0, 0,      0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0,      0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,      0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,      1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,      0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,      1, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,      0, 2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1,      0, 2, 0, 0, 0, 1);
    add(0, 1, 3, 2, 2, 0, 0, 0,      0, 2, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0,      0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,      0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,      1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,      1, 2, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,      0, 2, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0,      0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0,      0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 1);
    add(0, 1, 5, 0, 0, 0, 0, 0,      0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0,      0, 0, 0, 0, 0, 1);
    add(0, 1, 5, 9, 0, 0, 0, 0,      0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0,      0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 1, 0, 1, 0, 0,      0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0,      0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,      1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1,      1, 2, 1, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      set_in(vt[i].rst, vt[i].cv, vt[i].pat, vt[i].len, vt[i].tgt, vt[i].st, vt[i].sp, vt[i].b);
      tick();
      chk($sformatf("row%0d out", i),   int'(dout),          vt[i].e_out);
      chk($sformatf("row%0d cnt", i),   int'(match_cnt),     vt[i].e_cnt);
      chk($sformatf("row%0d busy", i),  int'(busy),          vt[i].e_busy);
      chk($sformatf("row%0d done", i),  int'(done),          vt[i].e_done);
      chk($sformatf("row%0d err", i),   int'(cfg_err),       vt[i].e_err);
      chk($sformatf("row%0d ready", i), int'(cif.cfg_ready), vt[i].e_rdy);
    end

    // Reset in the middle of a run drops the loaded configuration.
    set_in(1, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 1, 5, 3, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("midrst busy_before", int'(busy), 1);
    set_in(1, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("midrst out",   int'(dout),          0);
    chk("midrst cnt",   int'(match_cnt),     0);
    chk("midrst busy",  int'(busy),          0);
    chk("midrst done",  int'(done),          0);
    chk("midrst err",   int'(cfg_err),       0);
    chk("midrst ready", int'(cif.cfg_ready), 1);
    set_in(0, 0, 0, 0, 0, 1, 0, 0); tick();
    chk("midrst start_ignored", int'(busy), 0);
    set_in(0, 1, 5, 3, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 1, 0, 0); tick();
    chk("midrst rearm busy", int'(busy), 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("midrst lone1 out", int'(dout), 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("midrst 101 out", int'(dout), 1);
    chk("midrst 101 cnt", int'(match_cnt), 1);

    // Saturation on the 2-bit counter instance.
    set_in(1, 0, 0, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    sif.cfg_valid = 1'b1; sif.cfg_pattern = 8'd1; sif.cfg_len = 4'd1; sif.cfg_target = 2'd0;
    tick();
    sif.cfg_valid = 1'b0;
    s_start = 1'b1; tick();
    s_start = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      s_in = 1'b1; tick();
      chk($sformatf("sat%0d out", n), int'(s_out), 1);
      chk($sformatf("sat%0d cnt", n), int'(s_cnt), (n < 3) ? n : 3);
    end
    s_in = 1'b0; tick();
    chk("sat hold out",  int'(s_out),  0);
    chk("sat hold cnt",  int'(s_cnt),  3);
    chk("sat hold busy", int'(s_busy), 1);
    chk("sat done",      int'(s_done), 0);
    chk("sat err",       int'(s_err),  0);

    // Random traffic against the reference model.
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      int r, cv, p, l, t, st, sp, b;
      r  = ($urandom_range(0, 149) == 0) ? 1 : 0;
      sp = ($urandom_range(0, 39) == 0) ? 1 : 0;
      st = ($urandom_range(0, 9) == 0) ? 1 : 0;
      cv = ($urandom_range(0, 7) == 0) ? 1 : 0;
      p  = int'($urandom_range(0, 255));
      l  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 9));
      t  = int'($urandom_range(0, 3));
      b  = int'($urandom_range(0, 1));
      set_in(r, cv, p, l, t, st, sp, b);
      model_step(r, cv, p, l, t, st, sp, b);
      tick();
      chk($sformatf("rnd%0d out", c),   int'(dout),          m_out);
      chk($sformatf("rnd%0d cnt", c),   int'(match_cnt),     m_cnt);
      chk($sformatf("rnd%0d busy", c),  int'(busy),          (m_mode == 1) ? 1 : 0);
      chk($sformatf("rnd%0d done", c),  int'(done),          (m_mode == 2) ? 1 : 0);
      chk($sformatf("rnd%0d err", c),   int'(cfg_err),       m_err);
      chk($sformatf("rnd%0d ready", c), int'(cif.cfg_ready), (m_mode == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire
